// File: rtl/pio_in_edge_irq_pkg.sv
// Shared constants for the input PIO: register word addresses and edge-select codes.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus for the input PIO: register access plus the level IRQ.
interface pio_in_edge_irq_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/pio_in_edge_irq_debounce_bit.sv
// One input bit: synchroniser chain followed by a stability-count debouncer.
module pio_debounce_bit #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic deb_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb_o = sync;
  end else begin : g_count
    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Counter tracks consecutive disagreeing cycles; it tops out at DEBOUNCE_CYCLES-1
    // because that is the cycle on which the debounced value is taken.
    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync != deb_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = sync;
        else                                   cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb_o = deb_q;
  end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Input PIO with per-bit debounce, edge capture (write-1-to-clear) and masked level IRQ.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  pio_in_edge_irq_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || EDGE_TYPE > EDGE_ANY) begin : g_bad_param
    $error("pio_in_edge_irq: illegal parameters WIDTH=%0d SYNC_STAGES=%0d EDGE_TYPE=%0d",
           WIDTH, SYNC_STAGES, EDGE_TYPE);
  end

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    zext = '0;
    zext[WIDTH-1:0] = v;
  endfunction

  logic [WIDTH-1:0] deb, prev_q, edge_hit, clr;
  logic [WIDTH-1:0] edgecap_q, edgecap_d, mask_q, mask_d;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d, wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .in_i   (in_port[i]),
      .deb_o  (deb[i])
    );
  end

  assign wr = bus.chipselect && !bus.write_n;

  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == EDGE_RISE)      edge_hit = deb & ~prev_q;
    else if (EDGE_TYPE == EDGE_FALL) edge_hit = ~deb & prev_q;
    else                             edge_hit = deb ^ prev_q;

    clr    = '0;
    mask_d = mask_q;
    if (wr && bus.address == ADDR_EDGECAP) clr    = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == ADDR_IRQMASK) mask_d = bus.writedata[WIDTH-1:0];

    // OR-ing the new edges after the clear lets a same-cycle edge survive.
    edgecap_d = (edgecap_q & ~clr) | edge_hit;
    irq_d     = |(edgecap_q & mask_q);

    rd_d = '0;
    case (bus.address)
      ADDR_DATA:    rd_d = zext(deb);
      ADDR_IRQMASK: rd_d = zext(mask_q);
      ADDR_EDGECAP: rd_d = zext(edgecap_q);
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      edgecap_q <= '0;
      mask_q    <= '0;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= deb;
      edgecap_q <= edgecap_d;
      mask_q    <= mask_d;
      rd_q      <= rd_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.readdata = rd_q;
  assign bus.irq      = irq_q;

endmodule
